hwpf_stride_arb: RTL and testbench
==================================

# hwpf_stride_arb

Request arbiter and response router that lets several stride prefetcher engines share one HPDcache request port. It sits between the prefetcher engines and the dcache. It grants engines in round-robin order, tags each forwarded request with the engine index in `tid`, and routes each dcache response back to its engine by that `tid`. A global outstanding-request counter caps the total number of prefetches in flight.

## Interface
Parameters:
- `NUM_HW_PREFETCH`, default 4: number of engines; legal range 1..16.
- `MAX_INFLIGHT`, default 8: maximum outstanding requests, all engines combined; must be ≥1.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `hwpf_req_valid_i`  in  NUM_HW_PREFETCH  per-engine request valid.
- `hwpf_req_ready_o`  out  NUM_HW_PREFETCH  per-engine request accepted.
- `hwpf_req_i`  in  NUM_HW_PREFETCH x hpdcache_req_t  per-engine request payload.
- `hwpf_rsp_valid_o`  out  NUM_HW_PREFETCH  per-engine response valid.
- `hwpf_rsp_o`  out  NUM_HW_PREFETCH x hpdcache_rsp_t  response payload, broadcast to all engines.
- `dcache_req_valid_o`  out  1  request to dcache.
- `dcache_req_ready_i`  in  1  dcache accepts request.
- `dcache_req_o`  out  hpdcache_req_t  forwarded request.
- `dcache_rsp_valid_i`  in  1  dcache response valid.
- `dcache_rsp_i`  in  hpdcache_rsp_t  dcache response.
- `inflight_o`  out  $clog2(MAX_INFLIGHT+1)  current outstanding count.
- `rsp_err_o`  out  1  one-cycle pulse on a response whose `tid` ≥ NUM_HW_PREFETCH.

## Operation
- Round-robin pointer `rr_q`, width $clog2(NUM_HW_PREFETCH) (minimum 1 bit).
  - Winner = first asserted `hwpf_req_valid_i` at or after `rr_q`, wrapping modulo NUM_HW_PREFETCH.
- Grant gating: no engine is granted while `inflight_q == MAX_INFLIGHT`. In that case `dcache_req_valid_o` stays 0.
- Request forwarding: `dcache_req_o` = winner payload, with `tid` overwritten by the zero-extended winner index. All other fields pass through unchanged.
- Handshake: `hwpf_req_ready_o[w] = dcache_req_ready_i` for the winner only. It is 0 for all other engines.
- On an accepted handshake (`valid && ready`):
  - `rr_q` ← (w+1) mod NUM_HW_PREFETCH.
  - `inflight_q` is incremented.
- Pointer hold: `rr_q` does not move without a handshake. A stalled winner keeps its grant, so the payload stays stable while valid is held.
- Response routing: on `dcache_rsp_valid_i`, `hwpf_rsp_valid_o[dcache_rsp_i.tid]` = 1 for one cycle, combinationally. `hwpf_rsp_o` is the `dcache_rsp_i` copy on every engine.
- Unknown `tid` (≥ NUM_HW_PREFETCH): the response is dropped, `rsp_err_o` = 1, and the decrement still applies.
- Counter rules:
  - Issue and response in the same cycle leave the count unchanged.
  - A response with `inflight_q == 0` does not decrement; the count saturates at 0 and `rsp_err_o` = 1.
- `inflight_o = inflight_q`.

## Timing
- Reset values:
  - `rr_q`=0, `inflight_q`=0.
  - All `hwpf_req_ready_o`=0, `hwpf_rsp_valid_o`=0, `dcache_req_valid_o`=0, `rsp_err_o`=0.
  - `dcache_req_o`=0 in registered mode.
- Default (unregistered) mode: request path is combinational, 0-cycle latency from engine valid to `dcache_req_valid_o`.
- Response path is always combinational, 0-cycle latency.
- Reset asserted mid-operation clears all state immediately. Outstanding responses arriving after reset trigger the zero-count rule (`rsp_err_o`).
- A winner change occurs only on the cycle after a handshake, or when the current winner's valid is low.

## Configuration
- `HWPF_STRIDE_ARB_OUT_REG_EN` defined: a one-entry output register is placed between arbitration and the dcache.
  - Arbitration and handshake: `hwpf_req_ready_o[w] = !full_q || dcache_req_ready_i`, gated by inflight. The winner is captured into the register on acceptance.
  - Outputs: `dcache_req_valid_o = full_q`.
  - Counter: `inflight_q` counts from engine acceptance and includes the buffered entry.
  - Latency: request latency is 1 cycle. Back-to-back throughput stays 1 per cycle.
- Macro undefined: fully combinational request path as described above.

## Test plan
- Reset, then all 4 engines valid and dcache ready held 1 → grants in order 0,1,2,3,0. `dcache_req_o.tid` = 0,1,2,3,0. `inflight_o` = 1..5.
- Engine 2 valid, `dcache_req_ready_i`=0 for 3 cycles, engine 3 raises valid at cycle 1 → grant stays on 2 with a stable payload. After ready, engine 2 is accepted, then engine 3.
- MAX_INFLIGHT=2 with two requests issued and no responses → `dcache_req_valid_o`=0 and all ready=0. A response with tid=1 → `hwpf_rsp_valid_o`=4'b0010 and `inflight_o`=1; issue resumes the next cycle.
- Issue and a tid=0 response in the same cycle with `inflight_o`=3 → stays 3 and `hwpf_rsp_valid_o[0]`=1.
- Response with tid=7 (N=4) → no `hwpf_rsp_valid_o`, `rsp_err_o` pulses, count decrements. Response at count 0 → count stays 0 and `rsp_err_o`=1.
- With `HWPF_STRIDE_ARB_OUT_REG_EN`: single request from engine 1 → `dcache_req_valid_o` rises 1 cycle after acceptance. Continuous ready sustains 1 request per cycle.

Source files
------------

// File: rtl/hwpf_stride_arb.sv
// hwpf_stride_arb: shares one HPDcache request port among several stride
// prefetcher engines. Requests are granted round-robin and tagged with the
// engine index in tid; responses are steered back to their engine by tid.
// A global outstanding counter caps the number of prefetches in flight.
//
// Optional build macro HWPF_STRIDE_ARB_OUT_REG_EN: inserts a one-entry
// output register between arbitration and the dcache request port.
// Without it the request path is purely combinational.

package hwpf_stride_arb_pkg;

    localparam int unsigned TID_W = 8;

    typedef struct packed {
        logic [31:0]      addr;
        logic [1:0]       op;
        logic [TID_W-1:0] tid;
    } hpdcache_req_t;

    typedef struct packed {
        logic [31:0]      rdata;
        logic             error;
        logic [TID_W-1:0] tid;
    } hpdcache_rsp_t;

endpackage

module hwpf_stride_arb
    import hwpf_stride_arb_pkg::*;
#(
    parameter int unsigned NUM_HW_PREFETCH = 4,
    parameter int unsigned MAX_INFLIGHT    = 8,
    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1),
    localparam int unsigned RR_W  = (NUM_HW_PREFETCH > 1) ? $clog2(NUM_HW_PREFETCH) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic          [NUM_HW_PREFETCH-1:0] hwpf_req_valid_i,
    output logic          [NUM_HW_PREFETCH-1:0] hwpf_req_ready_o,
    input  hpdcache_req_t [NUM_HW_PREFETCH-1:0] hwpf_req_i,
    output logic          [NUM_HW_PREFETCH-1:0] hwpf_rsp_valid_o,
    output hpdcache_rsp_t [NUM_HW_PREFETCH-1:0] hwpf_rsp_o,
    output logic                                dcache_req_valid_o,
    input  logic                                dcache_req_ready_i,
    output hpdcache_req_t                       dcache_req_o,
    input  logic                                dcache_rsp_valid_i,
    input  hpdcache_rsp_t                       dcache_rsp_i,
    output logic          [CNT_W-1:0]           inflight_o,
    output logic                                rsp_err_o
);

    logic [RR_W-1:0]  rr_q, rr_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;

    logic             found;
    logic [RR_W-1:0]  win;
    hpdcache_req_t    win_req;
    logic             can_issue;
    logic             slot_ready;
    logic             accept;
    logic             cnt_dec;

    // Round-robin search: first valid engine at or after rr_q, wrapping.
    always_comb begin
        int idx;
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < int'(NUM_HW_PREFETCH); i++) begin
            idx = int'(rr_q) + i;
            if (idx >= int'(NUM_HW_PREFETCH)) begin
                idx = idx - int'(NUM_HW_PREFETCH);
            end
            if (!found && hwpf_req_valid_i[idx]) begin
                found = 1'b1;
                win   = RR_W'(idx);
            end
        end
        win_req     = hwpf_req_i[win];
        win_req.tid = TID_W'(win);
    end

    assign can_issue = (inflight_q != CNT_W'(MAX_INFLIGHT));

`ifdef HWPF_STRIDE_ARB_OUT_REG_EN
    logic          full_q, full_d;
    hpdcache_req_t req_q, req_d;

    // The slot can take a new entry if empty or draining this cycle.
    assign slot_ready = !full_q || dcache_req_ready_i;

    // Output slot: load on engine acceptance, clear when drained without refill.
    always_comb begin
        full_d = full_q;
        req_d  = req_q;
        if (accept) begin
            full_d = 1'b1;
            req_d  = win_req;
        end else if (full_q && dcache_req_ready_i) begin
            full_d = 1'b0;
        end
    end

    // Output slot storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            // NOTE: the payload register is reset as well so that
            // dcache_req_o reads zero out of reset, not just its valid bit.
            req_q  <= '0;
        end else begin
            full_q <= full_d;
            req_q  <= req_d;
        end
    end

    assign dcache_req_valid_o = full_q;
    assign dcache_req_o       = req_q;
`else
    // Combinational path: the dcache ready is the winner's ready directly.
    assign slot_ready         = dcache_req_ready_i;
    assign dcache_req_valid_o = found && can_issue;
    assign dcache_req_o       = win_req;
`endif

    assign accept = found && can_issue && slot_ready;

    // Per-engine ready: only the winner sees the slot's ready.
    always_comb begin
        hwpf_req_ready_o = '0;
        if (found && can_issue) begin
            hwpf_req_ready_o[win] = slot_ready;
        end
    end

    // Response routing by tid; payload is broadcast to every engine.
    always_comb begin
        hwpf_rsp_valid_o = '0;
        hwpf_rsp_o       = '0;
        for (int i = 0; i < int'(NUM_HW_PREFETCH); i++) begin
            hwpf_rsp_valid_o[i] = dcache_rsp_valid_i && (dcache_rsp_i.tid == TID_W'(i));
            hwpf_rsp_o[i]       = dcache_rsp_i;
        end
        rsp_err_o = dcache_rsp_valid_i &&
                    ((dcache_rsp_i.tid >= TID_W'(NUM_HW_PREFETCH)) || (inflight_q == '0));
    end

    // Any response retires one request unless the count is already empty.
    assign cnt_dec = dcache_rsp_valid_i && (inflight_q != '0);

    // Next pointer and outstanding count.
    always_comb begin
        rr_d       = rr_q;
        inflight_d = inflight_q;
        if (accept) begin
            rr_d = (win == RR_W'(NUM_HW_PREFETCH - 1)) ? '0 : win + RR_W'(1);
        end
        case ({accept, cnt_dec})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            inflight_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values computed in the combinational blocks.
            rr_q       <= rr_d;
            inflight_q <= inflight_d;
        end
    end

    assign inflight_o = inflight_q;

endmodule

// File: tb/tb_hwpf_stride_arb.sv
// Self-checking bench for hwpf_stride_arb: table-driven vectors for the
// combinational request path plus hand-written multi-cycle sequences.
module tb_hwpf_stride_arb;
    import hwpf_stride_arb_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Main instance (MAX_INFLIGHT = 8)
    logic          [N-1:0] req_valid;
    logic          [N-1:0] req_ready;
    hpdcache_req_t [N-1:0] req_pl;
    logic          [N-1:0] rsp_vo;
    hpdcache_rsp_t [N-1:0] rsp_o;
    logic                  dc_valid;
    logic                  dc_ready;
    hpdcache_req_t         dc_req;
    logic                  rsp_valid;
    hpdcache_rsp_t         rsp;
    logic [3:0]            inflight;
    logic                  rsp_err;

    // Second instance (MAX_INFLIGHT = 2)
    logic          [N-1:0] v2;
    logic          [N-1:0] rdy2_o;
    logic          [N-1:0] rsp_vo2;
    hpdcache_rsp_t [N-1:0] rsp_o2;
    logic                  dc_valid2;
    logic                  dc_ready2;
    hpdcache_req_t         dc_req2;
    logic                  rsp_valid2;
    hpdcache_rsp_t         rsp2;
    logic [1:0]            inflight2;
    logic                  rsp_err2;

    hwpf_stride_arb #(.NUM_HW_PREFETCH(N), .MAX_INFLIGHT(8)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .hwpf_req_valid_i(req_valid), .hwpf_req_ready_o(req_ready), .hwpf_req_i(req_pl),
        .hwpf_rsp_valid_o(rsp_vo), .hwpf_rsp_o(rsp_o),
        .dcache_req_valid_o(dc_valid), .dcache_req_ready_i(dc_ready), .dcache_req_o(dc_req),
        .dcache_rsp_valid_i(rsp_valid), .dcache_rsp_i(rsp),
        .inflight_o(inflight), .rsp_err_o(rsp_err)
    );

    hwpf_stride_arb #(.NUM_HW_PREFETCH(N), .MAX_INFLIGHT(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n),
        .hwpf_req_valid_i(v2), .hwpf_req_ready_o(rdy2_o), .hwpf_req_i(req_pl),
        .hwpf_rsp_valid_o(rsp_vo2), .hwpf_rsp_o(rsp_o2),
        .dcache_req_valid_o(dc_valid2), .dcache_req_ready_i(dc_ready2), .dcache_req_o(dc_req2),
        .dcache_rsp_valid_i(rsp_valid2), .dcache_rsp_i(rsp2),
        .inflight_o(inflight2), .rsp_err_o(rsp_err2)
    );

    int tests  = 0;
    int failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic hpdcache_rsp_t mk_rsp(input logic [7:0] t);
        hpdcache_rsp_t r;
        r.rdata = {24'hCAFE00, t};
        r.error = 1'b0;
        r.tid   = t;
        return r;
    endfunction

    function automatic logic [31:0] exp_addr(input logic [7:0] t);
        return 32'h1000 + 32'(t) * 32'd16;
    endfunction

    typedef struct {
        logic [3:0] valid;
        logic       rdy;
        logic       rv;
        logic [7:0] rtid;
        logic       dv;
        logic [7:0] dtid;
        logic [3:0] hrdy;
        logic       chk_rsp;
        logic [3:0] rmask;
        logic       err;
        logic [3:0] infl;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] valid, input logic rdy, input logic rv,
                                input logic [7:0] rtid, input logic dv, input logic [7:0] dtid,
                                input logic [3:0] hrdy, input logic chk_rsp,
                                input logic [3:0] rmask, input logic err, input logic [3:0] infl);
        vec_t v;
        v.valid = valid; v.rdy = rdy; v.rv = rv; v.rtid = rtid;
        v.dv = dv; v.dtid = dtid; v.hrdy = hrdy; v.chk_rsp = chk_rsp;
        v.rmask = rmask; v.err = err; v.infl = infl;
        return v;
    endfunction

    vec_t vecs[21];

    initial begin
        // Engine payloads carry a bogus tid to prove it gets overwritten.
        for (int i = 0; i < N; i++) begin
            req_pl[i].addr = 32'h1000 + 32'(i) * 32'd16;
            req_pl[i].op   = 2'(i);
            req_pl[i].tid  = 8'hFF;
        end
        rst_n = 1'b0;
        req_valid = '0; dc_ready = 1'b0; rsp_valid = 1'b0; rsp = mk_rsp(8'd0);
        v2 = '0; dc_ready2 = 1'b0; rsp_valid2 = 1'b0; rsp2 = mk_rsp(8'd0);

        // Round robin over all engines, stalled winner, responses, counter edges.
        //             valid  rdy rv rtid   dv dtid  hrdy  chk rmask err infl
        vecs[0]  = mk(4'hF, 1, 0, 8'd0, 1, 8'd0, 4'h1, 1, 4'h0, 0, 4'd0);
        vecs[1]  = mk(4'hF, 1, 0, 8'd0, 1, 8'd1, 4'h2, 1, 4'h0, 0, 4'd1);
        vecs[2]  = mk(4'hF, 1, 0, 8'd0, 1, 8'd2, 4'h4, 1, 4'h0, 0, 4'd2);
        vecs[3]  = mk(4'hF, 1, 0, 8'd0, 1, 8'd3, 4'h8, 1, 4'h0, 0, 4'd3);
        vecs[4]  = mk(4'hF, 1, 0, 8'd0, 1, 8'd0, 4'h1, 1, 4'h0, 0, 4'd4);
        vecs[5]  = mk(4'h4, 0, 0, 8'd0, 1, 8'd2, 4'h0, 1, 4'h0, 0, 4'd5);
        vecs[6]  = mk(4'hC, 0, 0, 8'd0, 1, 8'd2, 4'h0, 1, 4'h0, 0, 4'd5);
        vecs[7]  = mk(4'hC, 0, 0, 8'd0, 1, 8'd2, 4'h0, 1, 4'h0, 0, 4'd5);
        vecs[8]  = mk(4'hC, 1, 0, 8'd0, 1, 8'd2, 4'h4, 1, 4'h0, 0, 4'd5);
        vecs[9]  = mk(4'h8, 1, 0, 8'd0, 1, 8'd3, 4'h8, 1, 4'h0, 0, 4'd6);
        vecs[10] = mk(4'h0, 1, 1, 8'd0, 0, 8'd0, 4'h0, 1, 4'h1, 0, 4'd7);
        vecs[11] = mk(4'h0, 1, 1, 8'd7, 0, 8'd0, 4'h0, 1, 4'h0, 1, 4'd6);
        vecs[12] = mk(4'h0, 1, 1, 8'd1, 0, 8'd0, 4'h0, 1, 4'h2, 0, 4'd5);
        vecs[13] = mk(4'h0, 1, 1, 8'd3, 0, 8'd0, 4'h0, 1, 4'h8, 0, 4'd4);
        vecs[14] = mk(4'h2, 1, 1, 8'd0, 1, 8'd1, 4'h2, 1, 4'h1, 0, 4'd3);
        vecs[15] = mk(4'h0, 0, 0, 8'd0, 0, 8'd0, 4'h0, 1, 4'h0, 0, 4'd3);
        vecs[16] = mk(4'h0, 0, 1, 8'd2, 0, 8'd0, 4'h0, 1, 4'h4, 0, 4'd3);
        vecs[17] = mk(4'h0, 0, 1, 8'd0, 0, 8'd0, 4'h0, 1, 4'h1, 0, 4'd2);
        vecs[18] = mk(4'h0, 0, 1, 8'd1, 0, 8'd0, 4'h0, 1, 4'h2, 0, 4'd1);
        vecs[19] = mk(4'h0, 0, 1, 8'd2, 0, 8'd0, 4'h0, 0, 4'h0, 1, 4'd0);
        vecs[20] = mk(4'h0, 0, 0, 8'd0, 0, 8'd0, 4'h0, 1, 4'h0, 0, 4'd0);

        // Reset state
        #12;
        check("reset inflight", 64'(inflight), 64'd0);
        check("reset dc_valid", 64'(dc_valid), 64'd0);
        check("reset req_ready", 64'(req_ready), 64'd0);
        check("reset rsp_valid", 64'(rsp_vo), 64'd0);
        check("reset rsp_err", 64'(rsp_err), 64'd0);
`ifdef HWPF_STRIDE_ARB_OUT_REG_EN
        check("reset dc_req", 64'(dc_req), 64'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

`ifdef HWPF_STRIDE_ARB_OUT_REG_EN
        // Single request from engine 1 appears one cycle after acceptance.
        req_valid = 4'h2; dc_ready = 1'b1;
        @(negedge clk);
        check("reg acc ready", 64'(req_ready), 64'h2);
        check("reg acc dv", 64'(dc_valid), 64'd0);
        @(posedge clk); #1;
        req_valid = 4'h0;
        @(negedge clk);
        check("reg out dv", 64'(dc_valid), 64'd1);
        check("reg out tid", 64'(dc_req.tid), 64'd1);
        check("reg out addr", 64'(dc_req.addr), 64'(exp_addr(8'd1)));
        check("reg out infl", 64'(inflight), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("reg drained dv", 64'(dc_valid), 64'd0);
        @(posedge clk); #1;
        // Continuous ready: one request per cycle, pointer now at engine 2.
        req_valid = 4'hF;
        @(negedge clk);
        check("reg bb first ready", 64'(req_ready), 64'h4);
        check("reg bb first dv", 64'(dc_valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            logic [7:0] et;
            et = 8'((2 + k) % 4);
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("reg bb%0d dv", k), 64'(dc_valid), 64'd1);
            check($sformatf("reg bb%0d tid", k), 64'(dc_req.tid), 64'(et));
            check($sformatf("reg bb%0d ready", k), 64'(req_ready), 64'(4'h1 << ((3 + k) % 4)));
        end
        @(posedge clk); #1;
        req_valid = '0;
`else
        // Table-driven vectors on the main instance.
        for (int i = 0; i < 21; i++) begin
            req_valid = vecs[i].valid;
            dc_ready  = vecs[i].rdy;
            rsp_valid = vecs[i].rv;
            rsp       = mk_rsp(vecs[i].rtid);
            @(negedge clk);
            check($sformatf("v%0d dc_valid", i), 64'(dc_valid), 64'(vecs[i].dv));
            if (vecs[i].dv) begin
                check($sformatf("v%0d tid", i), 64'(dc_req.tid), 64'(vecs[i].dtid));
                check($sformatf("v%0d addr", i), 64'(dc_req.addr), 64'(exp_addr(vecs[i].dtid)));
            end
            check($sformatf("v%0d req_ready", i), 64'(req_ready), 64'(vecs[i].hrdy));
            if (vecs[i].chk_rsp)
                check($sformatf("v%0d rsp_valid", i), 64'(rsp_vo), 64'(vecs[i].rmask));
            check($sformatf("v%0d rsp_err", i), 64'(rsp_err), 64'(vecs[i].err));
            check($sformatf("v%0d inflight", i), 64'(inflight), 64'(vecs[i].infl));
            if (vecs[i].rv)
                check($sformatf("v%0d rsp bcast", i), 64'(rsp_o[3].rdata), 64'({24'hCAFE00, vecs[i].rtid}));
            @(posedge clk); #1;
        end

        // Two more grants continue from the pointer (engine 2 then 3).
        req_valid = 4'hF; dc_ready = 1'b1; rsp_valid = 1'b0;
        @(negedge clk);
        check("pre-rst tid a", 64'(dc_req.tid), 64'd2);
        @(posedge clk); #1;
        @(negedge clk);
        check("pre-rst tid b", 64'(dc_req.tid), 64'd3);
        @(posedge clk); #1;
        check("pre-rst inflight", 64'(inflight), 64'd2);

        // Mid-operation reset clears state immediately.
        req_valid = 4'h0; dc_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid rst inflight", 64'(inflight), 64'd0);
        check("mid rst dc_valid", 64'(dc_valid), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        // Stale response after reset hits the zero-count rule.
        rsp_valid = 1'b1; rsp = mk_rsp(8'd1);
        @(negedge clk);
        check("stale rsp err", 64'(rsp_err), 64'd1);
        check("stale rsp inflight", 64'(inflight), 64'd0);
        @(posedge clk); #1;
        rsp_valid = 1'b0;
        req_valid = 4'hF; dc_ready = 1'b1;
        @(negedge clk);
        check("post rst inflight", 64'(inflight), 64'd0);
        check("post rst tid", 64'(dc_req.tid), 64'd0);
        check("post rst ready", 64'(req_ready), 64'h1);
        @(posedge clk); #1;
        req_valid = 4'h0; dc_ready = 1'b0;

        // Cap at MAX_INFLIGHT = 2 on the second instance.
        v2 = 4'hF; dc_ready2 = 1'b1;
        @(negedge clk);
        check("cap g0 tid", 64'(dc_req2.tid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("cap g1 tid", 64'(dc_req2.tid), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("cap full dv", 64'(dc_valid2), 64'd0);
        check("cap full ready", 64'(rdy2_o), 64'h0);
        check("cap full inflight", 64'(inflight2), 64'd2);
        @(posedge clk); #1;
        rsp_valid2 = 1'b1; rsp2 = mk_rsp(8'd1);
        @(negedge clk);
        check("cap rsp mask", 64'(rsp_vo2), 64'h2);
        check("cap rsp dv", 64'(dc_valid2), 64'd0);
        @(posedge clk); #1;
        rsp_valid2 = 1'b0;
        @(negedge clk);
        check("cap resume inflight", 64'(inflight2), 64'd1);
        check("cap resume dv", 64'(dc_valid2), 64'd1);
        check("cap resume tid", 64'(dc_req2.tid), 64'd2);
        check("cap resume ready", 64'(rdy2_o), 64'h4);
        @(posedge clk); #1;
        v2 = 4'h0; dc_ready2 = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
